// File: rtl/foo_fifo.sv
// foo_fifo: registered valid/ready buffer of DEPTH words of WIDTH bits.
// Words leave in arrival order; occupancy and an almost-full flag are exported.
// A synchronous flush empties the buffer; rst clears it asynchronously.
module foo_fifo #(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 4,
  parameter  int AFULL_LVL = 3,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             almost_full
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             push;
  logic             pop;

  // Pointers wrap by explicit compare so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshakes. in_ready depends only on registered state and flush, so it
  // never forms a combinational loop with the producer's in_valid.
  assign in_ready    = (count != CW'(DEPTH)) && !flush;
  assign out_valid   = (count != '0);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready && !flush;
  assign out_data    = mem[rd_ptr];
  assign almost_full = (count >= CW'(AFULL_LVL));

  // Next occupancy: push and pop together leave it unchanged.
  always_comb begin
    // NOTE: default first so every path assigns count_nxt; no latch is inferred.
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage write on push.
  // NOTE: the array has no reset; its contents are don't-care until written,
  // and leaving it out of reset lets it map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Pointer and occupancy registers; flush clears them at the next edge.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count_nxt;
    end
  end

endmodule
